// File: rtl/pipelined_csa_adder_if.sv
// Operand/result bus of the pipelined carry-select adder: input handshake,
// operands and mode on one side, result handshake and flags on the other.
interface pipelined_csa_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_csa_adder.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready flow control.
// Stage 1 precomputes per-group candidate sums; stage 2 resolves carries by muxing.
module pipelined_csa_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  pipelined_csa_adder_if.slave bus
);
  localparam int NG = WIDTH / BLOCK;
  // Groups above group 0 carry two candidates; keep at least one slot so NG == 1 elaborates.
  localparam int NH = (NG > 1) ? NG - 1 : 1;

  typedef logic [BLOCK-1:0] grp_t;

  if ((WIDTH < 8) || (WIDTH > 64) || (WIDTH % BLOCK != 0)) begin : g_param_check
    $error("pipelined_csa_adder: WIDTH must be 8..64 and a multiple of BLOCK");
  end

  logic             advance_1;
  logic             advance_2;
  logic             s1_valid;
  logic             s2_valid;

  logic [WIDTH-1:0] b_eff;
  logic             c_in;
  grp_t             g0_sum_n;
  logic             g0_c_n;
  grp_t             sum0_n [NH];
  grp_t             sum1_n [NH];
  logic [NH-1:0]    c0_n;
  logic [NH-1:0]    c1_n;

  grp_t             s1_g0_sum;
  logic             s1_g0_c;
  grp_t             s1_sum0 [NH];
  grp_t             s1_sum1 [NH];
  logic [NH-1:0]    s1_c0;
  logic [NH-1:0]    s1_c1;
  logic             s1_amsb;
  logic             s1_bmsb;

  logic [WIDTH-1:0] sum_n;
  logic             carry;
  logic             cout_n;
  logic             ovf_n;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  assign advance_2     = ~s2_valid | bus.out_ready;
  assign advance_1     = ~s1_valid | advance_2;
  assign bus.in_ready  = advance_1 & ~rst;
  assign bus.out_valid = s2_valid;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

  // Subtraction is a + ~b + 1, so the forced carry-in replaces cin.
  always_comb begin
    b_eff = bus.sub ? ~bus.b : bus.b;
    c_in  = bus.sub | bus.cin;
    {g0_c_n, g0_sum_n} = {1'b0, bus.a[BLOCK-1:0]} + {1'b0, b_eff[BLOCK-1:0]}
                       + {{BLOCK{1'b0}}, c_in};
    for (int g = 0; g < NH; g++) begin
      sum0_n[g] = '0;
      sum1_n[g] = '0;
      c0_n[g]   = 1'b0;
      c1_n[g]   = 1'b0;
    end
    for (int g = 1; g < NG; g++) begin
      {c0_n[g-1], sum0_n[g-1]} = {1'b0, bus.a[g*BLOCK +: BLOCK]} + {1'b0, b_eff[g*BLOCK +: BLOCK]};
      {c1_n[g-1], sum1_n[g-1]} = {1'b0, bus.a[g*BLOCK +: BLOCK]} + {1'b0, b_eff[g*BLOCK +: BLOCK]}
                               + {{BLOCK{1'b0}}, 1'b1};
    end
  end

  // NOTE: only the valid bits need reset; datapath registers are qualified by them, so
  // leaving the candidate arrays unreset saves reset fan-out without exposing stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (advance_1) begin
      s1_valid  <= bus.in_valid;
      s1_g0_sum <= g0_sum_n;
      s1_g0_c   <= g0_c_n;
      s1_sum0   <= sum0_n;
      s1_sum1   <= sum1_n;
      s1_c0     <= c0_n;
      s1_c1     <= c1_n;
      s1_amsb   <= bus.a[WIDTH-1];
      s1_bmsb   <= b_eff[WIDTH-1];
    end
  end

  // NOTE: carry is a blocking ripple through the loop on purpose; each group reads the
  // carry produced by the group below it within the same evaluation.
  always_comb begin
    sum_n            = '0;
    sum_n[BLOCK-1:0] = s1_g0_sum;
    carry            = s1_g0_c;
    for (int g = 1; g < NG; g++) begin
      sum_n[g*BLOCK +: BLOCK] = carry ? s1_sum1[g-1] : s1_sum0[g-1];
      carry                   = carry ? s1_c1[g-1]   : s1_c0[g-1];
    end
    cout_n = carry;
    ovf_n  = (s1_amsb == s1_bmsb) && (sum_n[WIDTH-1] != s1_amsb);
  end

  // NOTE: sequential state uses non-blocking assignments so both stages sample the
  // pre-edge values of each other and the pipeline shifts cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (advance_2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sum_q  <= sum_n;
        cout_q <= cout_n;
        ovf_q  <= ovf_n;
      end
    end
  end
endmodule

// File: tb/tb_pipelined_csa_adder.sv
// Self-checking bench: drives a 16/4 and a 32/8 instance with identical stimulus and
// scores both against an arithmetic reference model with in-order expectation queues.
module tb_pipelined_csa_adder;
  localparam int W0 = 16;
  localparam int B0 = 4;
  localparam int W1 = 32;
  localparam int B1 = 8;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [63:0] a_v, b_v;
  logic        cin_v, sub_v, in_valid_v, out_ready_v;

  pipelined_csa_adder_if #(.WIDTH(W0)) bus0 ();
  pipelined_csa_adder_if #(.WIDTH(W1)) bus1 ();

  assign bus0.in_valid  = in_valid_v;
  assign bus0.a         = a_v[W0-1:0];
  assign bus0.b         = b_v[W0-1:0];
  assign bus0.cin       = cin_v;
  assign bus0.sub       = sub_v;
  assign bus0.out_ready = out_ready_v;
  assign bus1.in_valid  = in_valid_v;
  assign bus1.a         = a_v[W1-1:0];
  assign bus1.b         = b_v[W1-1:0];
  assign bus1.cin       = cin_v;
  assign bus1.sub       = sub_v;
  assign bus1.out_ready = out_ready_v;

  pipelined_csa_adder #(.WIDTH(W0), .BLOCK(B0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  pipelined_csa_adder #(.WIDTH(W1), .BLOCK(B1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic chk_lat;
  exp_t q0[$];
  exp_t q1[$];
  vec_t dv [6];

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(int w, logic [63:0] a, logic [63:0] b, logic cin, logic sub);
    logic [64:0] m, aa, bb, full;
    exp_t r;
    m      = (65'd1 << w) - 65'd1;
    aa     = {1'b0, a} & m;
    bb     = (sub ? ~{1'b0, b} : {1'b0, b}) & m;
    full   = aa + bb + {64'd0, (sub ? 1'b1 : cin)};
    r.sum  = full[63:0] & m[63:0];
    r.cout = full[w];
    r.ovf  = (aa[w-1] == bb[w-1]) && (r.sum[w-1] != aa[w-1]);
    r.cyc  = 0;
    return r;
  endfunction

  task automatic observe(int k, logic ird, logic ovl, logic [63:0] s, logic co, logic ov);
    exp_t e;
    int   n;
    if (rst) begin
      if (k == 0) q0.delete(); else q1.delete();
      return;
    end
    n = (k == 0) ? q0.size() : q1.size();
    if (n == 0) begin
      check($sformatf("d%0d idle_out_valid", k), {63'd0, ovl}, 64'd0);
    end else if (ovl && out_ready_v) begin
      if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
      check($sformatf("d%0d sum", k), s, e.sum);
      check($sformatf("d%0d cout", k), {63'd0, co}, {63'd0, e.cout});
      check($sformatf("d%0d ovf", k), {63'd0, ov}, {63'd0, e.ovf});
      if (chk_lat) check($sformatf("d%0d latency", k), 64'(cyc - e.cyc), 64'd2);
    end
    if (in_valid_v && ird) begin
      e     = model((k == 0) ? W0 : W1, a_v, b_v, cin_v, sub_v);
      e.cyc = cyc;
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  // Sample just after the falling edge, advance through one rising edge, return at the next falling edge.
  task automatic cycle();
    #1;
    observe(0, bus0.in_ready, bus0.out_valid, 64'(bus0.sum), bus0.cout, bus0.ovf);
    observe(1, bus1.in_ready, bus1.out_valid, 64'(bus1.sum), bus1.cout, bus1.ovf);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(logic v, logic [63:0] a, logic [63:0] b, logic ci, logic su);
    in_valid_v = v;
    a_v        = a;
    b_v        = b;
    cin_v      = ci;
    sub_v      = su;
  endtask

  task automatic drive_rand(logic v);
    drive(v, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          run0, run1, acc0, acc1;
    logic [63:0] held0, held1;

    dv[0] = '{64'hF000, 64'h0001, 1'b0, 1'b0, 16'hF001, 1'b0, 1'b0};
    dv[1] = '{64'hFFFF, 64'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0};
    dv[2] = '{64'hFFFF, 64'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    dv[3] = '{64'h7FFF, 64'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    dv[4] = '{64'h0005, 64'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    dv[5] = '{64'hFFFF_FFFF, 64'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};

    rst         = 1'b1;
    chk_lat     = 1'b1;
    out_ready_v = 1'b1;
    drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // Reset state
    check("rst in_ready d0", {63'd0, bus0.in_ready}, 64'd0);
    check("rst in_ready d1", {63'd0, bus1.in_ready}, 64'd0);
    check("rst out_valid d0", {63'd0, bus0.out_valid}, 64'd0);
    check("rst out_valid d1", {63'd0, bus1.out_valid}, 64'd0);
    check("rst sum d0", 64'(bus0.sum), 64'd0);
    check("rst flags d0", {62'd0, bus0.cout, bus0.ovf}, 64'd0);
    check("rst sum d1", 64'(bus1.sum), 64'd0);
    rst = 1'b0;
    #1;
    check("post-rst in_ready d0", {63'd0, bus0.in_ready}, 64'd1);
    check("post-rst in_ready d1", {63'd0, bus1.in_ready}, 64'd1);

    // Directed vectors with the known 16-bit answers, one transfer at a time
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, dv[k].a, dv[k].b, dv[k].cin, dv[k].sub);
      cycle();
      drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
      check($sformatf("vec%0d one-cycle out_valid", k), {63'd0, bus0.out_valid}, 64'd0);
      cycle();
      check($sformatf("vec%0d out_valid", k), {63'd0, bus0.out_valid}, 64'd1);
      check($sformatf("vec%0d sum", k), 64'(bus0.sum), 64'(dv[k].sum));
      check($sformatf("vec%0d cout", k), {63'd0, bus0.cout}, {63'd0, dv[k].cout});
      check($sformatf("vec%0d ovf", k), {63'd0, bus0.ovf}, {63'd0, dv[k].ovf});
      if (k == 5) begin
        check("wrap32 sum", 64'(bus1.sum), 64'd0);
        check("wrap32 cout", {63'd0, bus1.cout}, 64'd1);
      end
      cycle();
    end

    // Ten back-to-back transfers with the consumer always ready
    run0 = 0;
    run1 = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) drive(1'b1, 64'hFFFF_FFFF, 64'd1, 1'b0, 1'b0);
      else        drive_rand(1'b1);
      #1;
      check("stream in_ready d0", {63'd0, bus0.in_ready}, 64'd1);
      check("stream in_ready d1", {63'd0, bus1.in_ready}, 64'd1);
      cycle();
      run0 += int'(bus0.out_valid);
      run1 += int'(bus1.out_valid);
    end
    drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      run0 += int'(bus0.out_valid);
      run1 += int'(bus1.out_valid);
    end
    check("stream valid count d0", 64'(run0), 64'd10);
    check("stream valid count d1", 64'(run1), 64'd10);

    // Backpressure from an empty pipeline: two accepts, then held outputs
    chk_lat     = 1'b0;
    out_ready_v = 1'b0;
    acc0        = 0;
    acc1        = 0;
    held0       = '0;
    held1       = '0;
    for (int i = 0; i < 5; i++) begin
      drive_rand(1'b1);
      #1;
      acc0 += int'(bus0.in_ready);
      acc1 += int'(bus1.in_ready);
      if (i >= 2) begin
        check("stall in_ready d0", {63'd0, bus0.in_ready}, 64'd0);
        check("stall in_ready d1", {63'd0, bus1.in_ready}, 64'd0);
        check("stall out_valid d0", {63'd0, bus0.out_valid}, 64'd1);
      end
      if (i >= 3) begin
        check("stall hold d0", {bus0.cout, bus0.ovf, 46'd0, bus0.sum}, held0);
        check("stall hold d1", {bus1.cout, bus1.ovf, 30'd0, bus1.sum}, held1);
      end
      held0 = {bus0.cout, bus0.ovf, 46'd0, bus0.sum};
      held1 = {bus1.cout, bus1.ovf, 30'd0, bus1.sum};
      cycle();
    end
    check("stall accepts d0", 64'(acc0), 64'd2);
    check("stall accepts d1", 64'(acc1), 64'd2);
    drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    out_ready_v = 1'b1;
    repeat (4) cycle();
    check("drain empty d0", 64'(q0.size()), 64'd0);
    check("drain empty d1", 64'(q1.size()), 64'd0);

    // Reset with two results in flight
    chk_lat = 1'b1;
    drive_rand(1'b1);
    cycle();
    drive_rand(1'b1);
    cycle();
    drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("mid-rst in_ready d0", {63'd0, bus0.in_ready}, 64'd0);
    cycle();
    check("mid-rst out_valid d0", {63'd0, bus0.out_valid}, 64'd0);
    check("mid-rst out_valid d1", {63'd0, bus1.out_valid}, 64'd0);
    check("mid-rst sum d0", 64'(bus0.sum), 64'd0);
    check("mid-rst sum d1", 64'(bus1.sum), 64'd0);
    rst = 1'b0;
    #1;
    check("after mid-rst in_ready d0", {63'd0, bus0.in_ready}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("no stale d0", {63'd0, bus0.out_valid}, 64'd0);
      check("no stale d1", {63'd0, bus1.out_valid}, 64'd0);
    end

    // Random traffic with random backpressure
    chk_lat = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drive_rand(1'($urandom_range(0, 3) != 0));
      out_ready_v = 1'($urandom_range(0, 3) != 0);
      cycle();
    end
    drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    out_ready_v = 1'b1;
    repeat (4) cycle();
    check("final empty d0", 64'(q0.size()), 64'd0);
    check("final empty d1", 64'(q1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
